mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: turns one pipeline load/store operation into a data-memory
// read or write transaction, waits for the memory's completion events with a
// cycle timeout, then returns a single result to the pipeline.
//
// Handshakes: a transfer on any valid/ready pair happens on the rising edge
// where both are high; valid never waits on ready, and a raised valid stays
// raised (with its payload stable) until that transfer happens.
//
// Optional feature: define MEM_ACCESS_ALIGN_CHECK_EN to reject operations whose
// address is not a multiple of the access size (resp_err = 2'b10, no memory
// request). Without it, misaligned addresses are passed to memory unchanged.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic        op_is_store,
    input  logic        op_signed,
    input  logic [63:0] op_address,
    input  logic [1:0]  op_size,
    input  logic [63:0] op_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic [1:0]  resp_err,
    output logic        read_request,
    output logic        write_request,
    input  logic        read_ready,
    input  logic        write_ready,
    input  logic        write_finished,
    output logic [63:0] address,
    output logic [1:0]  block_size,
    output logic [63:0] write_data,
    input  logic [63:0] read_data,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_REQ = 3'd1,
        S_WR_REQ = 3'd2,
        S_WR_FIN = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    localparam logic [1:0] SZ_DOUBLE = 2'b11;
    localparam logic [1:0] SZ_WORD   = 2'b00;
    localparam logic [1:0] SZ_HALF   = 2'b01;
    localparam logic [1:0] SZ_BYTE   = 2'b10;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_MISALIGN = 2'b10;

    // Last count value of a waiting state; reaching it without the event times out.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

    state_t      state_q, state_d;
    logic        signed_q, signed_d;
    logic [63:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] resp_data_q, resp_data_d;
    logic [1:0]  resp_err_q, resp_err_d;
    logic [15:0] cnt_q, cnt_d;
    logic        align_fault;

    // Keep only the bytes the store actually writes; upper bytes read as zero.
    function automatic logic [63:0] mask_wdata(input logic [63:0] d, input logic [1:0] sz);
        case (sz)
            SZ_BYTE: return {56'd0, d[7:0]};
            SZ_HALF: return {48'd0, d[15:0]};
            SZ_WORD: return {32'd0, d[31:0]};
            default: return d;
        endcase
    endfunction

    // Select the loaded bytes and extend them to 64 bits.
    function automatic logic [63:0] load_ext(input logic [63:0] rd, input logic [1:0] sz,
                                             input logic sgn);
        case (sz)
            SZ_BYTE: return sgn ? {{56{rd[7]}}, rd[7:0]}   : {56'd0, rd[7:0]};
            SZ_HALF: return sgn ? {{48{rd[15]}}, rd[15:0]} : {48'd0, rd[15:0]};
            SZ_WORD: return sgn ? {{32{rd[31]}}, rd[31:0]} : {32'd0, rd[31:0]};
            default: return rd;
        endcase
    endfunction

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    // Low address bits that must be zero for an access of the given size.
    function automatic logic [2:0] align_bits(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: return 3'b000;
            SZ_HALF: return 3'b001;
            SZ_WORD: return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    assign align_fault = |(op_address[2:0] & align_bits(op_size));
`else
    assign align_fault = 1'b0;
`endif

    // State register and operation/result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            signed_q    <= 1'b0;
            addr_q      <= 64'd0;
            size_q      <= 2'b00;
            wdata_q     <= 64'd0;
            resp_data_q <= 64'd0;
            resp_err_q  <= ERR_OK;
            cnt_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            signed_q    <= signed_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state logic: accept, wait for memory events with timeout, respond.
    always_comb begin
        state_d     = state_q;
        signed_d    = signed_q;
        addr_d      = addr_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    signed_d    = op_signed;
                    addr_d      = op_address;
                    size_d      = op_size;
                    wdata_d     = mask_wdata(op_wdata, op_size);
                    resp_data_d = 64'd0;
                    resp_err_d  = ERR_OK;
                    cnt_d       = 16'd0;
                    if (align_fault) begin
                        resp_err_d = ERR_MISALIGN;
                        state_d    = S_RESP;
                    end else if (op_is_store) begin
                        state_d = S_WR_REQ;
                    end else begin
                        state_d = S_RD_REQ;
                    end
                end
            end

            S_RD_REQ: begin
                // The awaited event is checked before the timeout, so it wins a tie.
                if (read_ready) begin
                    resp_data_d = load_ext(read_data, size_q, signed_q);
                    state_d     = S_RESP;
                end else if (cnt_q == TO_LAST) begin
                    resp_err_d = ERR_TIMEOUT;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_WR_REQ: begin
                if (write_ready) begin
                    cnt_d   = 16'd0;
                    state_d = S_WR_FIN;
                end else if (cnt_q == TO_LAST) begin
                    resp_err_d = ERR_TIMEOUT;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_WR_FIN: begin
                if (write_finished) begin
                    state_d = S_RESP;
                end else if (cnt_q == TO_LAST) begin
                    resp_err_d = ERR_TIMEOUT;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All memory and pipeline outputs derive from registered state only.
    assign op_ready      = (state_q == S_IDLE);
    assign read_request  = (state_q == S_RD_REQ);
    assign write_request = (state_q == S_WR_REQ);
    assign resp_valid    = (state_q == S_RESP);
    assign resp_data     = resp_data_q;
    assign resp_err      = resp_err_q;
    assign address       = (read_request || write_request) ? addr_q : 64'd0;
    assign block_size    = (read_request || write_request) ? size_q : 2'b00;
    assign write_data    = write_request ? wdata_q : 64'd0;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized operations,
// with a byte-arithmetic reference model and an expected-response queue.
module tb_mem_access_unit;

  localparam int TO = 8;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic        op_is_store;
  logic        op_signed;
  logic [63:0] op_address;
  logic [1:0]  op_size;
  logic [63:0] op_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic [1:0]  resp_err;
  logic        read_request;
  logic        write_request;
  logic        read_ready;
  logic        write_ready;
  logic        write_finished;
  logic [63:0] address;
  logic [1:0]  block_size;
  logic [63:0] write_data;
  logic [63:0] read_data;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad = 0;
  logic [65:0] exp_q[$];

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .op_valid       (op_valid),
    .op_ready       (op_ready),
    .op_is_store    (op_is_store),
    .op_signed      (op_signed),
    .op_address     (op_address),
    .op_size        (op_size),
    .op_wdata       (op_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_data      (resp_data),
    .resp_err       (resp_err),
    .read_request   (read_request),
    .write_request  (write_request),
    .read_ready     (read_ready),
    .write_ready    (write_ready),
    .write_finished (write_finished),
    .address        (address),
    .block_size     (block_size),
    .write_data     (write_data),
    .read_data      (read_data),
    .dbg_state_o    (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    case (sz)
      2'b10: return 1;
      2'b01: return 2;
      2'b00: return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic [63:0] size_mask(input logic [1:0] sz);
    int nb;
    nb = nbytes(sz);
    if (nb == 8) return {64{1'b1}};
    return (64'd1 << (8 * nb)) - 64'd1;
  endfunction

  function automatic logic [63:0] load_model(input logic [63:0] rd, input logic [1:0] sz,
                                             input logic sgn);
    int nb;
    logic [63:0] m;
    logic [63:0] v;
    nb = nbytes(sz);
    m = size_mask(sz);
    v = rd & m;
    if (sgn && nb < 8 && v[8 * nb - 1]) v = v | ~m;
    return v;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_op_ready"}, 64'(op_ready), 64'd1);
    chk({tag, "_rd_req"}, 64'(read_request), 64'd0);
    chk({tag, "_wr_req"}, 64'(write_request), 64'd0);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_address"}, address, 64'd0);
  endtask

  // Issue one operation, act as data memory, then collect the response.
  // lat1: cycle index in the request state at which ready arrives (>= TO: never)
  // lat2: cycle index in the write-finish state at which finished arrives
  // hold: cycles resp_ready stays low once the response is up
  task automatic run_op(input logic st, input logic sgn, input logic [63:0] addr,
                        input logic [1:0] sz, input logic [63:0] wd, input logic [63:0] rd,
                        input int lat1, input int lat2, input int hold);
    logic mis;
    logic skip;
    logic done;
    logic done2;
    logic [65:0] exp;
    mis  = (addr & 64'(nbytes(sz) - 1)) != 64'd0;
    skip = 1'b0;
    done = 1'b0;

    // present the op in IDLE; it transfers on the next rising edge
    op_valid = 1'b1;
    op_is_store = st;
    op_signed = sgn;
    op_address = addr;
    op_size = sz;
    op_wdata = wd;
    chk("accept_op_ready", 64'(op_ready), 64'd1);
    step();
    op_valid = 1'b0;
    op_is_store = ~st;
    op_signed = ~sgn;
    op_address = {$urandom, $urandom};
    op_size = 2'($urandom_range(0, 3));
    op_wdata = {$urandom, $urandom};
    if (mis) mis = 1'b1;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    if (mis) begin
      exp_q.push_back({2'b10, 64'd0});
      skip = 1'b1;
    end
`endif

    if (!skip && !st) begin
      for (int c = 0; c < TO && !done; c++) begin
        chk("ld_rd_req", 64'(read_request), 64'd1);
        chk("ld_wr_req", 64'(write_request), 64'd0);
        chk("ld_address", address, addr);
        chk("ld_bsize", 64'(block_size), 64'(sz));
        write_ready = 1'($urandom_range(0, 1));
        write_finished = 1'($urandom_range(0, 1));
        if (c == lat1) begin
          read_data = rd;
          read_ready = 1'b1;
          exp_q.push_back({2'b00, load_model(rd, sz, sgn)});
          done = 1'b1;
        end else begin
          read_data = {$urandom, $urandom};
        end
        step();
        read_ready = 1'b0;
        write_ready = 1'b0;
        write_finished = 1'b0;
      end
      if (!done) exp_q.push_back({2'b01, 64'd0});
    end else if (!skip) begin
      for (int c = 0; c < TO && !done; c++) begin
        chk("st_wr_req", 64'(write_request), 64'd1);
        chk("st_rd_req", 64'(read_request), 64'd0);
        chk("st_address", address, addr);
        chk("st_bsize", 64'(block_size), 64'(sz));
        chk("st_wdata", write_data, wd & size_mask(sz));
        read_ready = 1'($urandom_range(0, 1));
        if (c == lat1) begin
          write_ready = 1'b1;
          done = 1'b1;
        end
        step();
        read_ready = 1'b0;
        write_ready = 1'b0;
      end
      if (!done) begin
        exp_q.push_back({2'b01, 64'd0});
      end else begin
        done2 = 1'b0;
        for (int d = 0; d < TO && !done2; d++) begin
          chk("fin_wr_req", 64'(write_request), 64'd0);
          chk("fin_rd_req", 64'(read_request), 64'd0);
          read_ready = 1'($urandom_range(0, 1));
          if (d == lat2) begin
            write_finished = 1'b1;
            done2 = 1'b1;
          end
          step();
          read_ready = 1'b0;
          write_finished = 1'b0;
        end
        exp_q.push_back(done2 ? {2'b00, 64'd0} : {2'b01, 64'd0});
      end
    end

    // response phase: outputs stable while resp_ready is low
    exp = exp_q.pop_front();
    chk("resp_rd_req", 64'(read_request), 64'd0);
    chk("resp_wr_req", 64'(write_request), 64'd0);
    for (int h = 0; h <= hold; h++) begin
      chk("resp_valid", 64'(resp_valid), 64'd1);
      chk("resp_data", resp_data, exp[63:0]);
      chk("resp_err", 64'(resp_err), 64'(exp[65:64]));
      chk("resp_op_ready", 64'(op_ready), 64'd0);
      if (h == hold) resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
    end
    chk("post_resp_valid", 64'(resp_valid), 64'd0);
    chk("post_op_ready", 64'(op_ready), 64'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic        r_st;
    logic        r_sgn;
    logic [63:0] r_addr;
    logic [1:0]  r_sz;

    reset = 1'b1;
    op_valid = 1'b0;
    op_is_store = 1'b0;
    op_signed = 1'b0;
    op_address = 64'd0;
    op_size = 2'b00;
    op_wdata = 64'd0;
    resp_ready = 1'b0;
    read_ready = 1'b0;
    write_ready = 1'b0;
    write_finished = 1'b0;
    read_data = 64'd0;
    repeat (3) step();

    // reset state
    chk_idle("reset");
    chk("reset_resp_data", resp_data, 64'd0);
    chk("reset_resp_err", 64'(resp_err), 64'd0);
    chk("reset_bsize", 64'(block_size), 64'd0);
    chk("reset_wdata", write_data, 64'd0);
    reset = 1'b0;
    step();
    chk_idle("post_reset");

    // signed byte load, immediate read_ready: response two cycles after acceptance
    run_op(1'b0, 1'b1, 64'h1000, 2'b10, 64'd0, 64'h0123_4567_89AB_CD80, 0, 0, 0);

    // half store with delayed write_ready and write_finished one cycle later
    run_op(1'b1, 1'b0, 64'h2000, 2'b01, 64'h1234_5678_9ABC_DEF0, 64'd0, 3, 0, 1);

    // read never answered: timeout after TO request cycles
    run_op(1'b0, 1'b0, 64'h3000, 2'b00, 64'd0, 64'd0, 100, 0, 0);

    // read answered in the very cycle the count reaches the limit: event wins
    run_op(1'b0, 1'b1, 64'h3008, 2'b01, 64'd0, 64'h0000_0000_0000_8001, TO - 1, 0, 0);

    // write_ready never comes; then write_finished never comes
    run_op(1'b1, 1'b0, 64'h4000, 2'b11, 64'hAAAA_5555_AAAA_5555, 64'd0, 100, 0, 0);
    run_op(1'b1, 1'b0, 64'h4008, 2'b00, 64'hCAFE_F00D_1234_5678, 64'd0, 0, 100, 0);

    // misaligned word load
    run_op(1'b0, 1'b0, 64'h1002, 2'b00, 64'd0, 64'hFFFF_FFFF_8765_4321, 0, 0, 0);

    // unsigned double load with response held off five cycles
    run_op(1'b0, 1'b0, 64'h5000, 2'b11, 64'd0, 64'h8000_0000_0000_0001, 2, 0, 5);

    // reset pulsed while a store is requesting: no response afterwards
    op_valid = 1'b1;
    op_is_store = 1'b1;
    op_address = 64'h6000;
    op_size = 2'b11;
    op_wdata = 64'h1111_2222_3333_4444;
    step();
    op_valid = 1'b0;
    chk("rst_mid_wr_req_before", 64'(write_request), 64'd1);
    reset = 1'b1;
    step();
    chk("rst_mid_wr_req", 64'(write_request), 64'd0);
    chk("rst_mid_resp_valid", 64'(resp_valid), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      write_ready = 1'b1;
      write_finished = 1'b1;
      step();
      chk("rst_after_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_after_wr_req", 64'(write_request), 64'd0);
      chk("rst_after_op_ready", 64'(op_ready), 64'd1);
    end
    write_ready = 1'b0;
    write_finished = 1'b0;

    // randomized operations
    for (int n = 0; n < 40; n++) begin
      r_st = 1'($urandom_range(0, 1));
      r_sgn = 1'($urandom_range(0, 1));
      r_sz = 2'($urandom_range(0, 3));
      r_addr = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) r_addr = r_addr & ~64'h7;
      run_op(r_st, r_sgn, r_addr, r_sz, {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 3));
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
